// File: rtl/stepper_motion_ctrl_pkg.sv
// Shared definitions for the two-axis stepper motion sequencer.
package stepper_motion_ctrl_pkg;

   localparam int STEP_W_DEF  = 16;
   localparam int CLK_DIV_DEF = 50000;
   localparam int PULSE_W_DEF = 100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } motion_state_e;

   // Every state other than IDLE counts as an active move.
   function automatic logic state_busy(motion_state_e s);
      return s != ST_IDLE;
   endfunction

endpackage

// File: rtl/stepper_motion_ctrl_if.sv
// Move-command handshake between the CPU-side MMIO logic and the motion sequencer.
interface stepper_motion_ctrl_if
   import stepper_motion_ctrl_pkg::*;
#(
   parameter int STEP_W = STEP_W_DEF
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic signed [STEP_W-1:0] cmd_dx;
   logic signed [STEP_W-1:0] cmd_dy;
   logic                     abort;

   modport master (
      output cmd_valid, cmd_dx, cmd_dy, abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dx, cmd_dy, abort,
      output cmd_ready
   );
endinterface

// File: rtl/stepper_motion_ctrl_timer.sv
// Interpolation tick timer. The outputs describe the cycle that begins at the
// next clock edge, so registered step outputs line up with the tick phase.
// The down-counter value 0 marks phase 0 of a tick; it idles there while run is low.
module step_tick_timer #(
   parameter int CLK_DIV = 50000,
   parameter int PULSE_W = 100
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic tick_start,
   output logic pulse_on,
   output logic tick_end
);
   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt;

   // Down-count through the tick period, reloading on terminal count.
   always_ff @(posedge clock) begin
      if (reset || !run)
         cnt <= '0;
      else if (cnt == '0)
         cnt <= CW'(CLK_DIV - 1);
      else
         cnt <= cnt - CW'(1);
   end

   assign tick_start = run & (cnt == '0);
   assign tick_end   = run & (cnt == CW'(1));
   assign pulse_on   = run & ((cnt == '0) | (cnt > CW'(CLK_DIV - PULSE_W)));

endmodule

// File: rtl/stepper_motion_ctrl.sv
// Two-axis DDA motion sequencer: one relative move per handshake, STEP/DIR out.
//
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready may be high
//   SETUP  | magnitudes latched, DIR settling ahead of the first STEP
//   RUN    | interpolating, one tick per CLK_DIV cycles
//   FINISH | move complete, done pulses as IDLE is entered
module stepper_motion_ctrl
   import stepper_motion_ctrl_pkg::*;
#(
   parameter int STEP_W  = STEP_W_DEF,
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int PULSE_W = PULSE_W_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   stepper_motion_ctrl_if.slave cmd,
   output logic                 step_x,
   output logic                 dir_x,
   output logic                 step_y,
   output logic                 dir_y,
   output logic                 busy,
   output logic                 done
);
   motion_state_e state, state_nxt;

   logic [STEP_W-1:0] abs_dx, abs_dy, n_cmd;
   logic [STEP_W-1:0] mag_x, mag_y, n_major, ticks_left;
   logic [STEP_W:0]   acc_x, acc_y, sum_x, sum_y;
   logic              fire_x, fire_y, fire_x_q, fire_y_q;
   logic              accept, timer_run, dda_tick;
   logic              tick_start, pulse_on, tick_end;

   // -(-2^(STEP_W-1)) wraps to the same bit pattern, which reads correctly as unsigned.
   assign abs_dx = cmd.cmd_dx[STEP_W-1] ? (~cmd.cmd_dx + STEP_W'(1)) : cmd.cmd_dx;
   assign abs_dy = cmd.cmd_dy[STEP_W-1] ? (~cmd.cmd_dy + STEP_W'(1)) : cmd.cmd_dy;
   assign n_cmd  = (abs_dx >= abs_dy) ? abs_dx : abs_dy;

   assign cmd.cmd_ready = (state == ST_IDLE) & ~cmd.abort & ~reset;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;

   // SETUP is included so the first tick is evaluated on the SETUP->RUN edge.
   assign timer_run = (state == ST_SETUP) | (state == ST_RUN);

   step_tick_timer #(
      .CLK_DIV (CLK_DIV),
      .PULSE_W (PULSE_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .run        (timer_run),
      .tick_start (tick_start),
      .pulse_on   (pulse_on),
      .tick_end   (tick_end)
   );

   assign sum_x  = acc_x + {1'b0, mag_x};
   assign sum_y  = acc_y + {1'b0, mag_y};
   assign fire_x = sum_x >= {1'b0, n_major};
   assign fire_y = sum_y >= {1'b0, n_major};

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode and the DDA tick strobe.
   always_comb begin
      state_nxt = state;
      dda_tick  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            if (n_major == '0) begin
               state_nxt = ST_FINISH;
            end else begin
               state_nxt = ST_RUN;
               dda_tick  = tick_start;
            end
         end
         ST_RUN: begin
            if (tick_start) begin
               if (ticks_left == '0)
                  state_nxt = ST_FINISH;
               else
                  dda_tick = 1'b1;
            end
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (cmd.abort && (state != ST_IDLE)) begin
         state_nxt = ST_IDLE;
         dda_tick  = 1'b0;
      end
   end

   // Command latch, DDA accumulators, tick countdown and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         mag_x      <= '0;
         mag_y      <= '0;
         n_major    <= '0;
         ticks_left <= '0;
         acc_x      <= '0;
         acc_y      <= '0;
         fire_x_q   <= 1'b0;
         fire_y_q   <= 1'b0;
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         step_x     <= 1'b0;
         step_y     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (accept) begin
            mag_x   <= abs_dx;
            mag_y   <= abs_dy;
            n_major <= n_cmd;
            acc_x   <= {1'b0, n_cmd >> 1};
            acc_y   <= {1'b0, n_cmd >> 1};
            dir_x   <= cmd.cmd_dx[STEP_W-1];
            dir_y   <= cmd.cmd_dy[STEP_W-1];
         end
         if (state == ST_SETUP)
            ticks_left <= n_major;
         else if ((state == ST_RUN) && tick_end)
            ticks_left <= ticks_left - STEP_W'(1);
         if (dda_tick) begin
            acc_x    <= fire_x ? (sum_x - {1'b0, n_major}) : sum_x;
            acc_y    <= fire_y ? (sum_y - {1'b0, n_major}) : sum_y;
            fire_x_q <= fire_x;
            fire_y_q <= fire_y;
         end
         step_x <= (state_nxt == ST_RUN) & pulse_on & (tick_start ? fire_x : fire_x_q);
         step_y <= (state_nxt == ST_RUN) & pulse_on & (tick_start ? fire_y : fire_y_q);
         busy   <= state_busy(state_nxt);
         done   <= (state == ST_FINISH) & ~cmd.abort;
      end
   end

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Directed bench for stepper_motion_ctrl with CLK_DIV=10, PULSE_W=3, STEP_W=16.
// Sample k of a trace is taken on the falling edge just before rising edge c_k,
// where c0 is the edge that accepts the command.
module tb_stepper_motion_ctrl;
   localparam int MAXC = 520;

   logic clock;
   logic reset;
   logic step_x, dir_x, step_y, dir_y, busy, done;

   int tests = 0;
   int fails = 0;

   // {dir_y, dir_x, ready, busy, done, step_y, step_x}
   logic [6:0] tr [0:MAXC];

   stepper_motion_ctrl_if #(.STEP_W(16)) ifc ();

   stepper_motion_ctrl #(
      .STEP_W  (16),
      .CLK_DIV (10),
      .PULSE_W (3)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .cmd    (ifc),
      .step_x (step_x),
      .dir_x  (dir_x),
      .step_y (step_y),
      .dir_y  (dir_y),
      .busy   (busy),
      .done   (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int count_rises(input int sel, input int n);
      int c;
      c = 0;
      for (int k = 1; k <= n; k++)
         if (tr[k][sel] && !tr[k-1][sel]) c++;
      return c;
   endfunction

   function automatic int rise_pos(input int sel, input int idx, input int n);
      int c;
      c = 0;
      for (int k = 1; k <= n; k++) begin
         if (tr[k][sel] && !tr[k-1][sel]) begin
            if (c == idx) return k;
            c++;
         end
      end
      return -1;
   endfunction

   function automatic int count_high(input int sel, input int n);
      int c;
      c = 0;
      for (int k = 1; k <= n; k++)
         if (tr[k][sel]) c++;
      return c;
   endfunction

   function automatic int bad_widths(input int sel, input int n);
      int bad, w, j;
      bad = 0;
      for (int k = 1; k <= n; k++) begin
         if (tr[k][sel] && !tr[k-1][sel]) begin
            w = 0;
            j = k;
            while (j <= n && tr[j][sel]) begin
               w++;
               j++;
            end
            if (j <= n && w != 3) bad++;
         end
      end
      return bad;
   endfunction

   task automatic issue(input logic signed [15:0] dx, input logic signed [15:0] dy);
      bit ok;
      ok = 1'b0;
      @(negedge clock);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_dx    = dx;
      ifc.cmd_dy    = dy;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (ifc.cmd_ready === 1'b1) ok = 1'b1;
         else @(negedge clock);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL issue_accept: cmd_ready got 0 expected 1 within 20 cycles");
      end else begin
         @(posedge clock);
      end
      #1 ifc.cmd_valid = 1'b0;
   endtask

   task automatic capture(input int n, input int abort_at, input int vlo, input int vhi,
                          input int rst_at, input bit chain,
                          input logic signed [15:0] cdx, input logic signed [15:0] cdy);
      bit chained;
      chained = 1'b0;
      tr[0] = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         tr[k] = {dir_y, dir_x, ifc.cmd_ready, busy, done, step_y, step_x};
         ifc.cmd_valid = ((k >= vlo) && (k < vhi)) || (chain && done && !chained);
         if (chain && done) chained = 1'b1;
         ifc.cmd_dx = cdx;
         ifc.cmd_dy = cdy;
         ifc.abort  = (k == abort_at);
         reset      = (k == rst_at);
      end
      ifc.cmd_valid = 1'b0;
      ifc.abort     = 1'b0;
      reset         = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] o;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      o = {step_x, dir_x, step_y, dir_y, busy, done};
      tests++;
      if (o !== 6'b0) begin fails++; $display("FAIL reset_outputs: got %b expected 000000", o); end
      tests++;
      if (ifc.cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ifc.cmd_ready); end
      reset = 1'b0;
      @(negedge clock);
      tests++;
      if (ifc.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b expected 1", ifc.cmd_ready); end
   endtask

   task automatic test_basic_move();
      int a;
      issue(16'sd4, 16'sd2);
      capture(50, 0, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      a = count_rises(0, 50);
      tests++; if (a !== 4) begin fails++; $display("FAIL t1_x_pulses: got %0d expected 4", a); end
      a = count_rises(1, 50);
      tests++; if (a !== 2) begin fails++; $display("FAIL t1_y_pulses: got %0d expected 2", a); end
      a = rise_pos(0, 0, 50);
      tests++; if (a !== 2) begin fails++; $display("FAIL t1_first_step: got c%0d expected c2", a); end
      a = rise_pos(1, 1, 50);
      tests++; if (a !== 22) begin fails++; $display("FAIL t1_y_second: got c%0d expected c22", a); end
      a = rise_pos(2, 0, 50);
      tests++; if (a !== 43) begin fails++; $display("FAIL t1_done_at: got c%0d expected c43", a); end
      a = count_high(2, 50);
      tests++; if (a !== 1) begin fails++; $display("FAIL t1_done_width: got %0d expected 1", a); end
      a = count_high(3, 50);
      tests++; if (a !== 42) begin fails++; $display("FAIL t1_busy_cycles: got %0d expected 42", a); end
      tests++; if (tr[1][6:5] !== 2'b00) begin fails++; $display("FAIL t1_dir: got %b expected 00", tr[1][6:5]); end
   endtask

   task automatic test_negative_dir();
      int a;
      issue(-16'sd3, 16'sd5);
      capture(60, 0, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      tests++; if (tr[1][6:5] !== 2'b01) begin fails++; $display("FAIL t2_dir_at_setup: got %b expected 01", tr[1][6:5]); end
      a = count_rises(0, 60);
      tests++; if (a !== 3) begin fails++; $display("FAIL t2_x_pulses: got %0d expected 3", a); end
      a = count_rises(1, 60);
      tests++; if (a !== 5) begin fails++; $display("FAIL t2_y_pulses: got %0d expected 5", a); end
      a = bad_widths(0, 60) + bad_widths(1, 60);
      tests++; if (a !== 0) begin fails++; $display("FAIL t2_pulse_width: got %0d bad expected 0", a); end
      a = rise_pos(1, 1, 60) - rise_pos(1, 0, 60);
      tests++; if (a !== 10) begin fails++; $display("FAIL t2_y_period: got %0d expected 10", a); end
      a = rise_pos(0, 1, 60);
      tests++; if (a !== 22) begin fails++; $display("FAIL t2_x_second: got c%0d expected c22", a); end
      a = count_high(3, 60);
      tests++; if (a !== 52) begin fails++; $display("FAIL t2_busy_cycles: got %0d expected 52", a); end
      a = rise_pos(2, 0, 60);
      tests++; if (a !== 53) begin fails++; $display("FAIL t2_done_at: got c%0d expected c53", a); end
      tests++; if (tr[60][5] !== 1'b1) begin fails++; $display("FAIL t2_dir_hold: got %b expected 1", tr[60][5]); end
   endtask

   task automatic test_zero_move();
      int a;
      issue(16'sd0, 16'sd0);
      capture(6, 0, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      a = count_rises(0, 6) + count_rises(1, 6);
      tests++; if (a !== 0) begin fails++; $display("FAIL t3_no_steps: got %0d expected 0", a); end
      a = rise_pos(2, 0, 6);
      tests++; if (a !== 3) begin fails++; $display("FAIL t3_done_at: got c%0d expected c3", a); end
      tests++; if (tr[1][4] !== 1'b0) begin fails++; $display("FAIL t3_ready_busy: got %b expected 0", tr[1][4]); end
      tests++; if (tr[3][4] !== 1'b1) begin fails++; $display("FAIL t3_ready_c3: got %b expected 1", tr[3][4]); end
   endtask

   task automatic test_back_to_back();
      int a;
      issue(16'sd0, 16'sd0);
      capture(35, 0, 0, 0, 0, 1'b1, 16'sd2, 16'sd1);
      tests++; if (tr[4][3] !== 1'b1) begin fails++; $display("FAIL b2b_busy_c4: got %b expected 1", tr[4][3]); end
      a = rise_pos(0, 0, 35);
      tests++; if (a !== 5) begin fails++; $display("FAIL b2b_first_step: got c%0d expected c5", a); end
      a = count_rises(0, 35) * 10 + count_rises(1, 35);
      tests++; if (a !== 21) begin fails++; $display("FAIL b2b_pulses: got x*10+y=%0d expected 21", a); end
      a = rise_pos(2, 1, 35);
      tests++; if (a !== 26) begin fails++; $display("FAIL b2b_second_done: got c%0d expected c26", a); end
   endtask

   task automatic test_abort();
      int a;
      issue(16'sd8, 16'sd8);
      capture(40, 23, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      tests++; if (tr[24][1:0] !== 2'b00) begin fails++; $display("FAIL ab_step_cut: got %b expected 00", tr[24][1:0]); end
      a = count_rises(0, 40) * 10 + count_rises(1, 40);
      tests++; if (a !== 33) begin fails++; $display("FAIL ab_pulses: got x*10+y=%0d expected 33", a); end
      tests++; if (tr[24][3] !== 1'b0) begin fails++; $display("FAIL ab_busy: got %b expected 0", tr[24][3]); end
      a = count_high(2, 40);
      tests++; if (a !== 0) begin fails++; $display("FAIL ab_no_done: got %0d expected 0", a); end
      issue(16'sd1, 16'sd0);
      capture(15, 0, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      a = rise_pos(2, 0, 15);
      tests++; if (a !== 13) begin fails++; $display("FAIL ab_next_done: got c%0d expected c13", a); end
   endtask

   task automatic test_abort_idle();
      @(negedge clock);
      ifc.abort     = 1'b1;
      ifc.cmd_valid = 1'b1;
      ifc.cmd_dx    = 16'sd3;
      ifc.cmd_dy    = 16'sd0;
      #1;
      tests++; if (ifc.cmd_ready !== 1'b0) begin fails++; $display("FAIL abidle_ready: got %b expected 0", ifc.cmd_ready); end
      @(negedge clock);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abidle_busy: got %b expected 0", busy); end
      ifc.abort     = 1'b0;
      ifc.cmd_valid = 1'b0;
   endtask

   task automatic test_ignore_while_busy();
      int a;
      issue(16'sd4, 16'sd2);
      capture(50, 0, 5, 30, 0, 1'b0, 16'sd1, 16'sd1);
      a = count_rises(0, 50) * 10 + count_rises(1, 50);
      tests++; if (a !== 42) begin fails++; $display("FAIL ign_pulses: got x*10+y=%0d expected 42", a); end
      a = rise_pos(2, 0, 50);
      tests++; if (a !== 43) begin fails++; $display("FAIL ign_done_at: got c%0d expected c43", a); end
      a = count_high(3, 50);
      tests++; if (a !== 42) begin fails++; $display("FAIL ign_busy: got %0d expected 42", a); end
   endtask

   task automatic test_reset_mid_move();
      int a;
      issue(-16'sd4, 16'sd2);
      capture(10, 0, 0, 0, 3, 1'b0, 16'sd0, 16'sd0);
      tests++; if (tr[2][5] !== 1'b1 || tr[2][0] !== 1'b1) begin fails++; $display("FAIL rst_pre: got %b expected dir_x=1 step_x=1", tr[2]); end
      tests++; if (tr[4] !== 7'b0) begin fails++; $display("FAIL rst_outputs: got %b expected 0000000", tr[4]); end
      tests++; if (tr[5][4] !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b expected 1", tr[5][4]); end
      a = count_rises(0, 10);
      tests++; if (a !== 1) begin fails++; $display("FAIL rst_pulses: got %0d expected 1", a); end
   endtask

   task automatic test_max_negative();
      int a;
      issue(16'sh8000, 16'sd16384);
      capture(500, 0, 0, 0, 0, 1'b0, 16'sd0, 16'sd0);
      tests++; if (tr[1][6:5] !== 2'b01) begin fails++; $display("FAIL max_dir: got %b expected 01", tr[1][6:5]); end
      a = count_rises(0, 500);
      tests++; if (a !== 50) begin fails++; $display("FAIL max_x_pulses: got %0d expected 50", a); end
      a = count_rises(1, 500);
      tests++; if (a !== 25) begin fails++; $display("FAIL max_y_pulses: got %0d expected 25", a); end
      tests++; if (tr[500][3] !== 1'b1) begin fails++; $display("FAIL max_busy: got %b expected 1", tr[500][3]); end
      @(negedge clock);
      ifc.abort = 1'b1;
      @(negedge clock);
      ifc.abort = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL max_abort: got busy %b expected 0", busy); end
   endtask

   initial begin
      reset         = 1'b1;
      ifc.cmd_valid = 1'b0;
      ifc.cmd_dx    = '0;
      ifc.cmd_dy    = '0;
      ifc.abort     = 1'b0;
      test_reset();
      test_basic_move();
      test_negative_dir();
      test_zero_move();
      test_back_to_back();
      test_abort();
      test_abort_idle();
      test_ignore_while_busy();
      test_reset_mid_move();
      test_max_negative();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
